// File: rtl/cache_pkg.sv
// Shared widths and encodings for the cache/memory arbitration slice.
package cache_pkg;

  localparam int unsigned C_BLOCK_SIZE = 2;
  localparam int unsigned C_LINE_SIZE  = 32;
  localparam int unsigned ADDRESS_SIZE = 32;
  localparam int unsigned AW = ADDRESS_SIZE - C_BLOCK_SIZE - 2;
  localparam int unsigned BW = (2 ** C_BLOCK_SIZE) * C_LINE_SIZE;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;
  typedef enum logic [1:0] {G_NONE, G_I, G_D} grant_t;

  // Control captured at grant for the transaction in flight
  typedef struct packed {
    grant_t grant;
    op_t    op;
  } txn_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker; bit 0 is the I-cache, bit 1 the D-cache.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;

  // On contention the pointer holder wins; a lone requester always wins
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr <= 1'b1;
    else if (advance && (req == 2'b11)) ptr <= ~ptr;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the block-wide memory port between I-cache and D-cache,
// sequencing the memory strobe against its busywait.
module mem_arbiter
  import cache_pkg::*;
#(
  parameter  int unsigned c_block_size = C_BLOCK_SIZE,
  parameter  int unsigned c_line_size  = C_LINE_SIZE,
  parameter  int unsigned address_size = ADDRESS_SIZE,
  localparam int unsigned AW_L = address_size - c_block_size - 2,
  localparam int unsigned BW_L = (2 ** c_block_size) * c_line_size
) (
  input  logic            a_clk_i,
  input  logic            a_reset_i,
  input  logic            i_read_i,
  input  logic [AW_L-1:0] i_addr_i,
  output logic            i_busywait_o,
  output logic [BW_L-1:0] i_read_data_o,
  input  logic            d_read_i,
  input  logic            d_wr_i,
  input  logic [AW_L-1:0] d_addr_i,
  input  logic [BW_L-1:0] d_wr_data_i,
  output logic            d_busywait_o,
  output logic [BW_L-1:0] d_read_data_o,
  output logic            m_read_o,
  output logic            m_wr_o,
  output logic [AW_L-1:0] m_addr_o,
  output logic [BW_L-1:0] m_wr_data_o,
  input  logic            m_busywait_i,
  input  logic [BW_L-1:0] m_read_data_i
);

  state_t          state;
  txn_t            txn;
  logic            seen_busy;
  logic [1:0]      req;
  logic [1:0]      gnt;
  logic            advance;
  logic            in_xfer;
  logic            busy_done;

  assign req     = {d_read_i | d_wr_i, i_read_i};
  assign advance = (state == IDLE) && (|req);

  rr_arb2 u_rr (
    .clk     (a_clk_i),
    .rst_n   (a_reset_i),
    .req     (req),
    .advance (advance),
    .gnt     (gnt)
  );

  // Strobe drops in the cycle busy falls so the memory cannot retrigger
  assign in_xfer   = (state == ISSUE) || (state == WAIT);
  assign busy_done = seen_busy && !m_busywait_i;
  assign m_read_o  = in_xfer && (txn.op == OP_RD) && !busy_done;
  assign m_wr_o    = in_xfer && (txn.op == OP_WR) && !busy_done;

  assign i_busywait_o = i_read_i && !((state == RESP) && (txn.grant == G_I));
  assign d_busywait_o = (d_read_i | d_wr_i) && !((state == RESP) && (txn.grant == G_D));

  always_ff @(posedge a_clk_i) begin
    if (!a_reset_i) begin
      state         <= IDLE;
      txn           <= '{grant: G_NONE, op: OP_RD};
      seen_busy     <= 1'b0;
      m_addr_o      <= '0;
      m_wr_data_o   <= '0;
      i_read_data_o <= '0;
      d_read_data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= ISSUE;
            seen_busy <= 1'b0;
            if (gnt[1]) begin
              // Simultaneous read and write from the D side: read wins
              txn         <= '{grant: G_D, op: (d_read_i ? OP_RD : OP_WR)};
              m_addr_o    <= d_addr_i;
              m_wr_data_o <= d_wr_data_i;
            end else begin
              txn      <= '{grant: G_I, op: OP_RD};
              m_addr_o <= i_addr_i;
            end
          end
        end
        ISSUE: begin
          if (m_busywait_i) begin
            seen_busy <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (!m_busywait_i) begin
            state <= RESP;
            if (txn.op == OP_RD) begin
              if (txn.grant == G_I) i_read_data_o <= m_read_data_i;
              else if (txn.grant == G_D) d_read_data_o <= m_read_data_i;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural block memory.
module tb_mem_arbiter;
  import cache_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic          i_busy;
  logic [BW-1:0] i_rdata;
  logic          d_read;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [BW-1:0] d_wdata;
  logic          d_busy;
  logic [BW-1:0] d_rdata;
  logic          m_read;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_wdata;
  logic          m_busy;
  logic [BW-1:0] m_rdata;

  int total = 0;
  int bad   = 0;

  mem_arbiter dut (
    .a_clk_i       (clk),
    .a_reset_i     (rst_n),
    .i_read_i      (i_read),
    .i_addr_i      (i_addr),
    .i_busywait_o  (i_busy),
    .i_read_data_o (i_rdata),
    .d_read_i      (d_read),
    .d_wr_i        (d_wr),
    .d_addr_i      (d_addr),
    .d_wr_data_i   (d_wdata),
    .d_busywait_o  (d_busy),
    .d_read_data_o (d_rdata),
    .m_read_o      (m_read),
    .m_wr_o        (m_wr),
    .m_addr_o      (m_addr),
    .m_wr_data_o   (m_wdata),
    .m_busywait_i  (m_busy),
    .m_read_data_i (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] blk(input logic [AW-1:0] a);
    return {4{32'hC0DE_0000 | 32'(a)}};
  endfunction

  // Memory model: starts on a strobe while idle, busy for mem_lat cycles
  logic [BW-1:0] mem [0:255];
  int            mcnt;
  logic [AW-1:0] maddr;
  logic          mwr;
  logic [BW-1:0] mwd;
  int            wr_starts;
  int            mem_lat = 4;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy    <= 1'b0;
      mcnt      <= 0;
      m_rdata   <= '0;
      wr_starts <= 0;
      for (int k = 0; k < 256; k++) mem[k] <= blk(AW'(k));
    end else if (!m_busy) begin
      if (m_read || m_wr) begin
        m_busy <= 1'b1;
        mcnt   <= mem_lat;
        maddr  <= m_addr;
        mwr    <= m_wr;
        mwd    <= m_wdata;
        if (m_wr) wr_starts <= wr_starts + 1;
      end
    end else begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        m_busy <= 1'b0;
        if (mwr) mem[maddr[7:0]] <= mwd;
        else m_rdata <= mem[maddr[7:0]];
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) assert (!(d_read && d_wr)) else $error("illegal simultaneous D read and write");
  end

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (m_read || m_wr) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_busy_fall(output bit ok);
    bit seen;
    seen = 1'b0;
    ok   = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (m_busy) seen = 1'b1;
      else if (seen) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_read = 1'b0; d_read = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if (m_read !== 1'b0) begin bad++; $display("FAIL reset_m_read got %b want 0", m_read); end
    total++; if (m_wr !== 1'b0) begin bad++; $display("FAIL reset_m_wr got %b want 0", m_wr); end
    total++; if (i_busy !== 1'b0) begin bad++; $display("FAIL reset_i_busy got %b want 0", i_busy); end
    total++; if (d_busy !== 1'b0) begin bad++; $display("FAIL reset_d_busy got %b want 0", d_busy); end
    total++; if (i_rdata !== '0) begin bad++; $display("FAIL reset_i_rdata got %h want 0", i_rdata); end
    total++; if (d_rdata !== '0) begin bad++; $display("FAIL reset_d_rdata got %h want 0", d_rdata); end
  endtask

  task automatic test_i_read;
    bit ok;
    i_read = 1'b1; i_addr = AW'(28'h10);
    wait_strobe(ok);
    total++; if (!ok) begin bad++; $display("FAIL iread_strobe_timeout got none want strobe"); end
    total++; if (m_read !== 1'b1) begin bad++; $display("FAIL iread_m_read got %b want 1", m_read); end
    total++; if (m_addr !== AW'(28'h10)) begin bad++; $display("FAIL iread_addr got %h want 10", m_addr); end
    wait_busy_fall(ok);
    total++; if (!ok) begin bad++; $display("FAIL iread_busy_timeout got none want fall"); end
    total++; if (m_read !== 1'b0) begin bad++; $display("FAIL iread_strobe_drop got %b want 0", m_read); end
    total++; if (i_busy !== 1'b1) begin bad++; $display("FAIL iread_busy_same got %b want 1", i_busy); end
    @(negedge clk);
    total++; if (i_busy !== 1'b0) begin bad++; $display("FAIL iread_busy_next got %b want 0", i_busy); end
    total++; if (i_rdata !== blk(AW'(28'h10))) begin bad++; $display("FAIL iread_data got %h want %h", i_rdata, blk(AW'(28'h10))); end
    i_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_d_write;
    bit ok;
    logic [BW-1:0] wd;
    wd = {16{8'hA5}};
    d_wr = 1'b1; d_addr = AW'(28'h20); d_wdata = wd;
    wait_strobe(ok);
    total++; if (!ok) begin bad++; $display("FAIL dwr_strobe_timeout got none want strobe"); end
    total++; if ({m_wr, m_read} !== 2'b10) begin bad++; $display("FAIL dwr_strobes got %b want 10", {m_wr, m_read}); end
    total++; if (m_addr !== AW'(28'h20)) begin bad++; $display("FAIL dwr_addr got %h want 20", m_addr); end
    total++; if (m_wdata !== wd) begin bad++; $display("FAIL dwr_wdata got %h want %h", m_wdata, wd); end
    wait_busy_fall(ok);
    total++; if (!ok) begin bad++; $display("FAIL dwr_busy_timeout got none want fall"); end
    total++; if (m_wr !== 1'b0) begin bad++; $display("FAIL dwr_strobe_drop got %b want 0", m_wr); end
    @(negedge clk);
    total++; if (d_busy !== 1'b0) begin bad++; $display("FAIL dwr_busy_next got %b want 0", d_busy); end
    d_wr = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (wr_starts !== 1) begin bad++; $display("FAIL dwr_reissue got %0d want 1", wr_starts); end
    i_read = 1'b1; i_addr = AW'(28'h20);
    wait_strobe(ok);
    wait_busy_fall(ok);
    total++; if (!ok) begin bad++; $display("FAIL dwr_rb_timeout got none want fall"); end
    @(negedge clk);
    total++; if (i_rdata !== wd) begin bad++; $display("FAIL dwr_readback got %h want %h", i_rdata, wd); end
    i_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [AW-1:0] ia [2];
    logic [AW-1:0] da [2];
    ia[0] = AW'(28'h40); da[0] = AW'(28'h50);
    ia[1] = AW'(28'h44); da[1] = AW'(28'h54);
    for (int r = 0; r < 2; r++) begin
      // Round 0 favours D (pointer at reset), round 1 favours I
      i_read = 1'b1; i_addr = ia[r]; d_read = 1'b1; d_addr = da[r];
      wait_strobe(ok);
      total++; if (!ok) begin bad++; $display("FAIL rr%0d_strobe_timeout got none want strobe", r); end
      total++; if (m_addr !== ((r == 0) ? da[r] : ia[r])) begin bad++; $display("FAIL rr%0d_first got %h want %h", r, m_addr, (r == 0) ? da[r] : ia[r]); end
      wait_busy_fall(ok);
      total++; if ((r == 0 ? i_busy : d_busy) !== 1'b1) begin bad++; $display("FAIL rr%0d_loser_busy got 0 want 1", r); end
      @(negedge clk);
      if (r == 0) begin
        total++; if (d_rdata !== blk(da[r])) begin bad++; $display("FAIL rr0_d_data got %h want %h", d_rdata, blk(da[r])); end
        d_read = 1'b0;
      end else begin
        total++; if (i_rdata !== blk(ia[r])) begin bad++; $display("FAIL rr1_i_data got %h want %h", i_rdata, blk(ia[r])); end
        i_read = 1'b0;
      end
      wait_strobe(ok);
      total++; if (m_addr !== ((r == 0) ? ia[r] : da[r])) begin bad++; $display("FAIL rr%0d_second got %h want %h", r, m_addr, (r == 0) ? ia[r] : da[r]); end
      wait_busy_fall(ok);
      @(negedge clk);
      if (r == 0) begin
        total++; if (i_rdata !== blk(ia[r])) begin bad++; $display("FAIL rr0_i_data got %h want %h", i_rdata, blk(ia[r])); end
      end else begin
        total++; if (d_rdata !== blk(da[r])) begin bad++; $display("FAIL rr1_d_data got %h want %h", d_rdata, blk(da[r])); end
      end
      i_read = 1'b0; d_read = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_capture;
    bit ok;
    logic [BW-1:0] wd;
    wd = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    d_wr = 1'b1; d_addr = AW'(28'h30); d_wdata = wd;
    wait_strobe(ok);
    for (int k = 0; k < 20 && !m_busy; k++) @(negedge clk);
    @(negedge clk);
    d_addr = AW'(28'h31); d_wdata = ~wd;
    @(negedge clk);
    total++; if (m_addr !== AW'(28'h30)) begin bad++; $display("FAIL cap_addr got %h want 30", m_addr); end
    total++; if (m_wdata !== wd) begin bad++; $display("FAIL cap_wdata got %h want %h", m_wdata, wd); end
    wait_busy_fall(ok);
    total++; if (!ok) begin bad++; $display("FAIL cap_busy_timeout got none want fall"); end
    @(negedge clk);
    d_wr = 1'b0;
    @(negedge clk);
    total++; if (mem[8'h30] !== wd) begin bad++; $display("FAIL cap_mem30 got %h want %h", mem[8'h30], wd); end
    total++; if (mem[8'h31] !== blk(AW'(28'h31))) begin bad++; $display("FAIL cap_mem31 got %h want %h", mem[8'h31], blk(AW'(28'h31))); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    i_read = 1'b1; i_addr = AW'(28'h60);
    wait_strobe(ok);
    for (int k = 0; k < 20 && !m_busy; k++) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++; if ({m_read, m_wr} !== 2'b00) begin bad++; $display("FAIL rstmid_strobes got %b want 00", {m_read, m_wr}); end
    total++; if (i_busy !== 1'b1) begin bad++; $display("FAIL rstmid_i_busy got %b want 1", i_busy); end
    total++; if (i_rdata !== '0) begin bad++; $display("FAIL rstmid_i_rdata got %h want 0", i_rdata); end
    rst_n = 1'b1; i_read = 1'b0;
    @(negedge clk);
    i_read = 1'b1; i_addr = AW'(28'h61);
    wait_strobe(ok);
    total++; if (m_addr !== AW'(28'h61)) begin bad++; $display("FAIL rstmid_addr got %h want 61", m_addr); end
    wait_busy_fall(ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_busy_timeout got none want fall"); end
    @(negedge clk);
    total++; if (i_busy !== 1'b0) begin bad++; $display("FAIL rstmid_done_busy got %b want 0", i_busy); end
    total++; if (i_rdata !== blk(AW'(28'h61))) begin bad++; $display("FAIL rstmid_data got %h want %h", i_rdata, blk(AW'(28'h61))); end
    i_read = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_i_read;
    test_d_write;
    test_back_to_back;
    test_capture;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
